// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serialising memory controller for fetch and load/store requests
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        inst_en_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  input  logic        data_en_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_addr_i,
  input  logic [2:0]  data_len_i,
  input  logic [31:0] data_i,
  output logic        data_valid_o,
  output logic [31:0] data_o,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [2:0] {IDLE, IFETCH, DREAD, DWRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  rcv_q, rcv_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        abort_q, abort_d;
  logic        first_q, first_d;
  logic        wr_q, wr_d;
  logic        ivalid_q, ivalid_d;
  logic        dvalid_q, dvalid_d;
  logic [31:0] mem_a_d;
  logic [7:0]  mem_dout_d;
  logic [31:0] inst_o_d, data_o_d;
  logic [31:0] rbuf_cap;

  // Zero every byte lane at or above the transfer length.
  function automatic logic [31:0] keep_bytes(input logic [31:0] v, input logic [2:0] n);
    case (n)
      3'd1:    keep_bytes = {24'b0, v[7:0]};
      3'd2:    keep_bytes = {16'b0, v[15:0]};
      3'd3:    keep_bytes = {8'b0, v[23:0]};
      default: keep_bytes = v;
    endcase
  endfunction

  // The write strobe drops immediately on a stall; the held byte is replayed once rdy returns.
  // A flush during the DONE cycle hides the completion pulse.
  assign mem_wr       = wr_q & rdy;
  assign data_valid_o = dvalid_q & ~clear;
  assign inst_valid_o = ivalid_q & ~clear;

  // Next-state and next-register computation for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rcv_d      = rcv_q;
    len_d      = len_q;
    base_d     = base_q;
    wbuf_d     = wbuf_q;
    rbuf_d     = rbuf_q;
    abort_d    = abort_q;
    first_d    = first_q;
    wr_d       = 1'b0;
    ivalid_d   = 1'b0;
    dvalid_d   = 1'b0;
    mem_a_d    = mem_a;
    mem_dout_d = mem_dout;
    inst_o_d   = inst_o;
    data_o_d   = data_o;
    rbuf_cap   = rbuf_q;
    rbuf_cap[{rcv_q[1:0], 3'b000} +: 8] = mem_din;

    case (state_q)
      IDLE: begin
        if (!clear && (data_en_i || inst_en_i)) begin
          cnt_d   = 3'd1;
          rcv_d   = 3'd0;
          rbuf_d  = '0;
          abort_d = 1'b0;
          first_d = 1'b1;
          if (data_en_i) begin
            base_d  = data_addr_i;
            len_d   = data_len_i;
            wbuf_d  = data_i;
            mem_a_d = data_addr_i;
            if (data_wr_i) begin
              state_d    = DWRITE;
              wr_d       = 1'b1;
              mem_dout_d = data_i[7:0];
            end else begin
              state_d = DREAD;
            end
          end else begin
            base_d  = inst_addr_i;
            len_d   = 3'd4;
            mem_a_d = inst_addr_i;
            state_d = IFETCH;
          end
        end
      end
      IFETCH, DREAD: begin
        if (clear) begin
          state_d = IDLE;
        end else begin
          if (cnt_q < len_q) begin
            mem_a_d = base_q + {29'b0, cnt_q};
            cnt_d   = cnt_q + 3'd1;
          end
          // RAM data trails the address by one cycle, so the first addressed cycle has nothing to capture.
          if (first_q) begin
            first_d = 1'b0;
          end else begin
            rbuf_d = rbuf_cap;
            rcv_d  = rcv_q + 3'd1;
            if (rcv_q + 3'd1 == len_q) begin
              state_d = DONE;
              if (state_q == IFETCH) begin
                ivalid_d = 1'b1;
                inst_o_d = keep_bytes(rbuf_cap, len_q);
              end else begin
                dvalid_d = 1'b1;
                data_o_d = keep_bytes(rbuf_cap, len_q);
              end
            end
          end
        end
      end
      DWRITE: begin
        // A committed store always finishes; a flush only silences its completion.
        if (clear) abort_d = 1'b1;
        if (cnt_q < len_q) begin
          mem_a_d    = base_q + {29'b0, cnt_q};
          mem_dout_d = wbuf_q[{cnt_q[1:0], 3'b000} +: 8];
          wr_d       = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d  = DONE;
          dvalid_d = ~(abort_q | clear);
          data_o_d = keep_bytes(rbuf_q, len_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; rdy low holds everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rcv_q    <= '0;
      len_q    <= '0;
      base_q   <= '0;
      wbuf_q   <= '0;
      rbuf_q   <= '0;
      abort_q  <= 1'b0;
      first_q  <= 1'b0;
      wr_q     <= 1'b0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      mem_a    <= '0;
      mem_dout <= '0;
      inst_o   <= '0;
      data_o   <= '0;
    end else if (rdy) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rcv_q    <= rcv_d;
      len_q    <= len_d;
      base_q   <= base_d;
      wbuf_q   <= wbuf_d;
      rbuf_q   <= rbuf_d;
      abort_q  <= abort_d;
      first_q  <= first_d;
      wr_q     <= wr_d;
      ivalid_q <= ivalid_d;
      dvalid_q <= dvalid_d;
      mem_a    <= mem_a_d;
      mem_dout <= mem_dout_d;
      inst_o   <= inst_o_d;
      data_o   <= data_o_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl against a byte-array memory model
module tb_mem_ctrl;

  logic        clk;
  logic        rst, rdy, clear;
  logic        inst_en_i, data_en_i, data_wr_i;
  logic [31:0] inst_addr_i, data_addr_i, data_i;
  logic [2:0]  data_len_i;
  logic        inst_valid_o, data_valid_o, mem_wr;
  logic [31:0] inst_o, data_o, mem_a;
  logic [7:0]  mem_din, mem_dout;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .inst_en_i(inst_en_i), .inst_addr_i(inst_addr_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o),
    .data_en_i(data_en_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i),
    .data_len_i(data_len_i), .data_i(data_i),
    .data_valid_o(data_valid_o), .data_o(data_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int cyc = 0;
  int both_cnt = 0;

  // Environment RAM (aliased on the low 16 address bits) and the reference memory image.
  logic [7:0]  ram [0:65535];
  logic        pl_en;
  logic [31:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  ref_mem [logic [31:0]];

  int          wl_cyc[$];
  logic [31:0] wl_addr[$];
  logic [7:0]  wl_data[$];
  int          dv_cyc[$];
  int          iv_cyc[$];

  // RAM with one-cycle read latency plus a preload port.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) ram[pl_addr[15:0]] <= pl_data;
    else if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  // Mid-cycle log of RAM writes and completion pulses.
  always @(negedge clk) begin
    if (mem_wr) begin
      wl_cyc.push_back(cyc);
      wl_addr.push_back(mem_a);
      wl_data.push_back(mem_dout);
    end
    if (data_valid_o) dv_cyc.push_back(cyc);
    if (inst_valid_o) iv_cyc.push_back(cyc);
    if (data_valid_o && inst_valid_o) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w = w | ({24'b0, ref_rd(a + 32'(i))} << (8 * i));
    return w;
  endfunction

  task automatic put_byte(input logic [31:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mem_a"}, mem_a, 32'h0);
    chk({tag, " mem_wr"}, {31'b0, mem_wr}, 32'h0);
    chk({tag, " mem_dout"}, {24'b0, mem_dout}, 32'h0);
    chk({tag, " inst_valid"}, {31'b0, inst_valid_o}, 32'h0);
    chk({tag, " data_valid"}, {31'b0, data_valid_o}, 32'h0);
    chk({tag, " inst_o"}, inst_o, 32'h0);
    chk({tag, " data_o"}, data_o, 32'h0);
  endtask

  // kind: 0 load, 1 store, 2 fetch. rdy is held low for s_n cycles starting at cycle s_at.
  task automatic xact(input string tag, input int kind, input logic [31:0] a, input int n,
                      input logic [31:0] d, input int s_at, input int s_n);
    int t0, wb, db, ib, c, lat;
    bit seen;
    logic [31:0] got;
    @(posedge clk); #1;
    t0 = cyc; wb = wl_cyc.size(); db = dv_cyc.size(); ib = iv_cyc.size();
    if (kind == 2) begin
      inst_en_i = 1'b1; inst_addr_i = a;
    end else begin
      data_en_i = 1'b1; data_wr_i = (kind == 1); data_addr_i = a;
      data_len_i = 3'(n); data_i = d;
    end
    seen = 1'b0; lat = 0; got = '0;
    for (int k = 1; k <= 24 && !seen; k++) begin
      @(posedge clk); #1;
      rdy = !(k >= s_at && k < s_at + s_n);
      @(negedge clk);
      if ((kind == 2) ? inst_valid_o : data_valid_o) begin
        seen = 1'b1; lat = cyc - t0;
        got = (kind == 2) ? inst_o : data_o;
        inst_en_i = 1'b0; data_en_i = 1'b0;
      end
    end
    rdy = 1'b1; inst_en_i = 1'b0; data_en_i = 1'b0;
    chk({tag, " seen"}, 32'(seen), 32'h1);
    chk({tag, " latency"}, lat, ((kind == 1) ? n + 1 : n + 2) + s_n);
    if (kind != 1) chk({tag, " rdata"}, got, ref_word(a, n));
    chk({tag, " other valid"}, (kind == 2) ? dv_cyc.size() - db : iv_cyc.size() - ib, 32'h0);
    chk({tag, " write count"}, wl_cyc.size() - wb, (kind == 1) ? n : 0);
    if (kind == 1) begin
      c = 0;
      for (int i = 0; i < n; i++) begin
        c++;
        while (c >= s_at && c < s_at + s_n) c++;
        if (wb + i < wl_cyc.size()) begin
          chk({tag, " wr addr"}, wl_addr[wb + i], a + 32'(i));
          chk({tag, " wr byte"}, {24'b0, wl_data[wb + i]}, {24'b0, d[8 * i +: 8]});
          chk({tag, " wr cycle"}, wl_cyc[wb + i] - t0, c);
        end
        ref_mem[a + 32'(i)] = d[8 * i +: 8];
      end
    end
  endtask

  initial begin
    int t0, db, wb, tdv, tiv, kind, n;
    bit dseen, iseen;
    logic [31:0] dval, ival, d, a;
    total = 0; bad = 0;
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    inst_en_i = 1'b0; inst_addr_i = '0; data_en_i = 1'b0; data_wr_i = 1'b0;
    data_addr_i = '0; data_len_i = '0; data_i = '0;

    put_byte(32'h0, 8'hA1); put_byte(32'h1, 8'hB2); put_byte(32'h2, 8'hC3); put_byte(32'h3, 8'hD4);
    put_byte(32'h100, 8'h11); put_byte(32'h101, 8'h22); put_byte(32'h102, 8'h33); put_byte(32'h103, 8'h44);
    put_byte(32'h200, 8'h55); put_byte(32'h201, 8'h66); put_byte(32'h202, 8'h77); put_byte(32'h203, 8'h88);
    put_byte(32'hFFFFFFFE, 8'h5A); put_byte(32'hFFFFFFFF, 8'hA5);
    for (int i = 0; i < 64; i++) put_byte(32'h300 + 32'(i), 8'($urandom));
    @(posedge clk); #1;
    pl_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk_zero("reset");

    xact("lw 0x100", 0, 32'h100, 4, 32'h0, 0, 0);
    chk("lw literal", data_o, 32'h44332211);
    xact("lbu 0x103", 0, 32'h103, 1, 32'h0, 0, 0);
    chk("lbu literal", data_o, 32'h00000044);
    xact("sh 0x200", 1, 32'h200, 2, 32'hDEADBEEF, 0, 0);
    chk("sh neighbour kept", {24'b0, ram[16'h0202]}, 32'h77);

    // Both requesters raised together: data first, fetch right after the DONE cycle.
    @(posedge clk); #1;
    t0 = cyc; dseen = 1'b0; iseen = 1'b0; tdv = 0; tiv = 0; dval = '0; ival = '0;
    data_en_i = 1'b1; data_wr_i = 1'b0; data_addr_i = 32'h100; data_len_i = 3'd4;
    inst_en_i = 1'b1; inst_addr_i = 32'h0;
    for (int k = 0; k < 30 && !(dseen && iseen); k++) begin
      @(negedge clk);
      if (data_valid_o && !dseen) begin dseen = 1'b1; tdv = cyc - t0; dval = data_o; data_en_i = 1'b0; end
      if (inst_valid_o && !iseen) begin iseen = 1'b1; tiv = cyc - t0; ival = inst_o; inst_en_i = 1'b0; end
    end
    data_en_i = 1'b0; inst_en_i = 1'b0;
    chk("arb data cycle", tdv, 32'd6);
    chk("arb data value", dval, ref_word(32'h100, 4));
    chk("arb fetch cycle", tiv, 32'd13);
    chk("arb fetch value", ival, ref_word(32'h0, 4));

    // Flush in cycle 3 of a load; a byte load issued in cycle 4 must be accepted at once.
    @(posedge clk); #1;
    t0 = cyc; db = dv_cyc.size();
    data_en_i = 1'b1; data_wr_i = 1'b0; data_addr_i = 32'h100; data_len_i = 3'd4;
    repeat (3) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; data_addr_i = 32'h101; data_len_i = 3'd1;
    dseen = 1'b0; tdv = 0; dval = '0;
    for (int k = 0; k < 12 && !dseen; k++) begin
      @(negedge clk);
      if (data_valid_o) begin dseen = 1'b1; tdv = cyc - t0; dval = data_o; data_en_i = 1'b0; end
    end
    data_en_i = 1'b0;
    chk("clear lw first valid", tdv, 32'd7);
    chk("clear lw next data", dval, ref_word(32'h101, 1));

    // Flush in cycle 2 of a store: all bytes still land, completion is silent.
    d = $urandom;
    @(posedge clk); #1;
    t0 = cyc; db = dv_cyc.size(); wb = wl_cyc.size();
    data_en_i = 1'b1; data_wr_i = 1'b1; data_addr_i = 32'h200; data_len_i = 3'd4; data_i = d;
    repeat (2) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; data_en_i = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    chk("clear sw valid count", dv_cyc.size() - db, 32'd0);
    chk("clear sw write count", wl_cyc.size() - wb, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (wb + i < wl_cyc.size()) begin
        chk("clear sw addr", wl_addr[wb + i], 32'h200 + 32'(i));
        chk("clear sw byte", {24'b0, wl_data[wb + i]}, {24'b0, d[8 * i +: 8]});
      end
      ref_mem[32'h200 + 32'(i)] = d[8 * i +: 8];
    end
    xact("lw after clear sw", 0, 32'h200, 4, 32'h0, 0, 0);

    // Wrapping store with a three-cycle stall, then read it back across the wrap.
    xact("sw wrap stall", 1, 32'hFFFFFFFE, 4, $urandom, 2, 3);
    xact("lw wrap", 0, 32'hFFFFFFFE, 4, 32'h0, 0, 0);

    // Reset in the middle of a load.
    @(posedge clk); #1;
    t0 = cyc; db = dv_cyc.size();
    data_en_i = 1'b1; data_wr_i = 1'b0; data_addr_i = 32'h300; data_len_i = 3'd4;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0; data_en_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid-read reset");
    repeat (6) begin @(posedge clk); #1; end
    chk("reset no valid", dv_cyc.size() - db, 32'd0);
    xact("lw after reset", 0, 32'h300, 4, 32'h0, 0, 0);

    // Random mix of loads, stores and fetches over a preloaded window.
    for (int r = 0; r < 24; r++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0: n = 1;
        1: n = 2;
        default: n = 4;
      endcase
      a = 32'h300 + 32'($urandom_range(0, 60));
      if (kind == 1 && $urandom_range(0, 1) == 1)
        xact("rand store stall", 1, a, n, $urandom, $urandom_range(1, n), $urandom_range(1, 3));
      else if (kind == 1)
        xact("rand store", 1, a, n, $urandom, 0, 0);
      else if (kind == 2)
        xact("rand fetch", 2, a, 4, 32'h0, 0, 0);
      else
        xact("rand load", 0, a, n, 32'h0, 0, 0);
    end

    chk("valids never concurrent", both_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller sitting directly downstream of the load/store buffer and the instruction-fetch unit. It accepts word, half-word and byte requests from both sides and serialises each into byte-wide accesses on the single-port unified RAM. It then returns assembled results with a one-cycle valid pulse. Data requests have priority over instruction fetches. A pipeline clear aborts speculative traffic but never truncates a committed store.

## Interface
- `clk` input 1: system clock
- `rst` input 1: synchronous, active-low reset
- `rdy` input 1: global ready; low freezes all state
- `clear` input 1: pipeline flush (misprediction)
- `inst_en_i` input 1: fetch request, level, held until `inst_valid_o`
- `inst_addr_i` input 32: fetch address
- `inst_valid_o` output 1: one-cycle pulse, `inst_o` valid
- `inst_o` output 32: fetched word, little-endian
- `data_en_i` input 1: LSB request, level, held until `data_valid_o`
- `data_wr_i` input 1: 1 = write, 0 = read
- `data_addr_i` input 32: byte address
- `data_len_i` input 3: byte count, one of 1, 2 or 4
- `data_i` input 32: store data; low `data_len_i` bytes are used
- `data_valid_o` output 1: one-cycle pulse, request complete
- `data_o` output 32: load result, zero-extended (the LSB does sign extension)
- `mem_din` input 8: RAM read byte, one-cycle latency
- `mem_dout` output 8: RAM write byte
- `mem_a` output 32: RAM byte address
- `mem_wr` output 1: RAM write strobe

## Operation
- States: IDLE, IFETCH, DREAD, DWRITE, DONE.
- Internal registers:
  - `cnt` (3 bit): bytes addressed so far
  - `rcv` (3 bit): bytes captured so far
  - `len`, `base` address, `wbuf` (32), `rbuf` (32)
  - `abort` (1)
- IDLE:
  - `data_en_i` high: latch `base`, `len`, `wbuf`; go to DWRITE or DREAD according to `data_wr_i`.
  - Else `inst_en_i` high: latch `inst_addr_i`, `len` = 4; go to IFETCH.
  - Data wins when both are high.
- DREAD / IFETCH:
  - While `cnt` < `len`: drive `mem_a` = `base` + `cnt`, `mem_wr` = 0, and increment `cnt`.
  - Each cycle after the first addressed cycle, capture `mem_din` into `rbuf` byte `rcv` and increment `rcv`.
  - When `rcv` reaches `len`: go to DONE.
- DWRITE:
  - Each cycle drive `mem_a` = `base` + `cnt`, `mem_dout` = `wbuf` byte `cnt`, `mem_wr` = 1.
  - After byte `len`-1 is written, go to DONE.
- DONE (exactly one cycle):
  - Pulse `data_valid_o` or `inst_valid_o` according to the transaction source, unless `abort` is set.
  - `data_o`/`inst_o` = `rbuf`, with bytes at index ≥ `len` zeroed.
  - Go to IDLE.
  - Requests seen during DONE are stale (the requester updates on the valid edge) and are ignored.
- clear:
  - In IDLE, IFETCH or DREAD: return to IDLE next cycle, drop the transaction, and emit no valid.
  - In DWRITE: the store is committed, so it runs to completion. Set `abort` so the DONE cycle emits no `data_valid_o`.
  - In DONE: suppress the valid pulse.
- Address arithmetic is 32-bit modulo 2^32; `base` + `cnt` wraps at 0xFFFFFFFF.
- `rdy` low: no state, counter or output-register change. `mem_wr` is forced to 0 for that cycle and the byte is re-driven when `rdy` returns.
- `rst` low (sampled at `clk`): go to IDLE and clear all counters and `abort`. Outputs reset to:
  - `mem_a` = 0, `mem_wr` = 0, `mem_dout` = 0
  - `inst_valid_o` = 0, `data_valid_o` = 0
  - `inst_o` = 0, `data_o` = 0
- Reset mid-write abandons the store; partial bytes remain in RAM.

## Timing
- All outputs are registered.
- Read of L bytes, request first seen in IDLE at cycle 0:
  - `mem_a` = `base`+0 … `base`+L-1 in cycles 1…L
  - byte i on `mem_din` in cycle i+2
  - valid pulse in cycle L+2 (LW and fetch: cycle 6; LB: cycle 3)
- Write of L bytes: `mem_wr` high in cycles 1…L; `data_valid_o` high in cycle L+1 (SW: cycle 5).
- Earliest next accept is the cycle after DONE, so back-to-back requests are separated by one DONE cycle plus the IDLE cycle.
- A fetch waiting behind data is accepted in the first IDLE cycle with `data_en_i` low.

## Test plan
- Read latency: RAM[0x100..0x103] = 11 22 33 44; LW at 0x100 (`data_len_i` = 4) → `data_o` = 0x44332211 with `data_valid_o` in cycle 6; LBU at 0x103 → `data_o` = 0x00000044 in cycle 3.
- Write: SH `data_i` = 0xDEADBEEF to 0x200 → `mem_wr` in cycles 1–2 with (0x200, EF), (0x201, BE); `data_valid_o` in cycle 3; RAM[0x202] unchanged.
- Arbitration: `inst_en_i` and `data_en_i` both raised in the same cycle → data served first. Fetch of 0x0 starts the cycle after data IDLE returns; `inst_valid_o` is never concurrent with `data_valid_o`.
- Clear: clear during cycle 3 of an LW → no `data_valid_o`, IDLE next cycle. Clear during cycle 2 of an SW → all 4 bytes written, no `data_valid_o`.
- Stall and wrap: SW at 0xFFFFFFFE with `rdy` low for 3 cycles mid-transfer → bytes land at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. No `mem_wr` during the stall; completion is delayed by exactly 3 cycles.
- Reset: `rst` low mid-DREAD → next cycle all outputs 0 and IDLE; a fresh LW then completes with nominal latency.
